// File: rtl/tight_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tight_acc_pkg
//  Description : Shared types and constants for the tight accelerator blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package tight_acc_pkg;

    localparam int          TACC_DATA_W   = 64;
    localparam logic [5:0]  TACC_OP_ISQRT = 6'b000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isqrt_state_e;

endpackage
`default_nettype wire

// File: rtl/tight_acc_isqrt_step.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_step
//  Description : One restoring square-root iteration (two radicand bits in).
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_step #(
    parameter int ROOT_W = 32
) (
    input  logic [ROOT_W+1:0] i_rem,
    input  logic [ROOT_W-1:0] i_root,
    input  logic [1:0]        i_bits,
    output logic [ROOT_W+1:0] o_rem,
    output logic [ROOT_W-1:0] o_root
);

    logic [ROOT_W+1:0] w_rem_sh;
    logic [ROOT_W+1:0] w_trial;
    logic              w_ge;

    assign w_rem_sh = (i_rem << 2) | {{ROOT_W{1'b0}}, i_bits};
    assign w_trial  = {i_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);

    assign o_rem  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign o_root = (i_root << 1) | {{(ROOT_W-1){1'b0}}, w_ge};

endmodule
`default_nettype wire

// File: rtl/tight_acc_isqrt.sv
`default_nettype none
// ============================================================================
//  Module      : tight_acc_isqrt
//  Description : Iterative unsigned integer square root, one bit-pair/cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tight_acc_isqrt
    import tight_acc_pkg::*;
#(
    parameter int DATA_W = TACC_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [DATA_W-1:0]   req_operand,
    input  logic                flush,
    output logic                busy,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [DATA_W/2-1:0] resp_root,
    output logic [DATA_W/2:0]   resp_rem
);

    localparam int ROOT_W = DATA_W / 2;
    localparam int ITERS  = DATA_W / 2;
    localparam int CNT_W  = $clog2(ITERS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(ITERS - 1);

    isqrt_state_e      r_state;
    isqrt_state_e      w_next_state;
    logic              w_accept;

    logic [DATA_W-1:0] r_opnd;
    logic [ROOT_W+1:0] r_rem;
    logic [ROOT_W-1:0] r_root;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROOT_W+1:0] w_rem_nxt;
    logic [ROOT_W-1:0] w_root_nxt;

    isqrt_step #(
        .ROOT_W (ROOT_W)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_opnd[DATA_W-1 -: 2]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A DONE entry with resp_rdy frees the slot in the same edge, so a new
    // operand can be taken without a bubble.
    always_comb begin
        w_next_state = r_state;
        req_rdy      = !flush && ((r_state == IDLE) || ((r_state == DONE) && resp_rdy));
        w_accept     = req_val && req_rdy;
        case (r_state)
            IDLE: if (w_accept) w_next_state = CALC;
            CALC: if (r_cnt == c_last) w_next_state = DONE;
            DONE: if (resp_rdy) w_next_state = w_accept ? CALC : IDLE;
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opnd <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_opnd <= req_operand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
        end else if (r_state == CALC) begin
            r_opnd <= r_opnd << 2;
            r_rem  <= w_rem_nxt;
            r_root <= w_root_nxt;
            r_cnt  <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign busy      = (r_state != IDLE);
    assign resp_val  = (r_state == DONE);
    assign resp_root = r_root;
    // Final remainder never exceeds 2*root, so the top accumulator bit is zero.
    assign resp_rem  = r_rem[ROOT_W:0];

endmodule
`default_nettype wire

// File: tb/tb_tight_acc_isqrt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tight_acc_isqrt
//  Description : Scoreboard bench for tight_acc_isqrt with a search-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tight_acc_isqrt;

    localparam int DW  = 64;
    localparam int LAT = 33;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic [DW-1:0] req_operand = '0;
    logic          flush = 1'b0;
    logic          busy;
    logic          resp_val;
    logic          resp_rdy = 1'b1;
    logic [31:0]   resp_root;
    logic [32:0]   resp_rem;

    tight_acc_isqrt #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_operand (req_operand),
        .flush       (flush),
        .busy        (busy),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_root   (resp_root),
        .resp_rem    (resp_rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        logic [31:0] root;
        logic [32:0] rem;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   seen   = 1'b0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Largest r with r*r <= x, found by bisection over the whole root range.
    function automatic void model(input logic [63:0] x, output logic [31:0] r, output logic [32:0] rem);
        logic [63:0] lo, hi, mid, d;
        lo = 64'd0;
        hi = 64'hFFFF_FFFF;
        while (lo < hi) begin
            mid = lo + (hi - lo + 64'd1) / 64'd2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid - 64'd1;
        end
        d   = x - lo * lo;
        r   = lo[31:0];
        rem = d[32:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
            seen = 1'b0;
        end else if (resp_val) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: got root=%h rem=%h expected no response", resp_root, resp_rem);
            end else begin
                if (!seen) begin
                    n_chk++;
                    if (cyc - sb[0].acc != LAT) begin
                        n_fail++;
                        $display("FAIL latency x=%h: got %0d expected %0d", sb[0].x, cyc - sb[0].acc, LAT);
                    end
                    seen = 1'b1;
                end
                n_chk++;
                if (resp_root !== sb[0].root || resp_rem !== sb[0].rem) begin
                    n_fail++;
                    $display("FAIL result x=%h: got root=%h rem=%h expected root=%h rem=%h",
                             sb[0].x, resp_root, resp_rem, sb[0].root, sb[0].rem);
                end
                if (resp_rdy) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end else if (sb.size() != 0) begin
            if (seen) begin
                n_chk++; n_fail++;
                $display("FAIL resp_dropped x=%h: got resp_val=0 expected 1", sb[0].x);
                void'(sb.pop_front());
                seen = 1'b0;
            end else if (cyc - sb[0].acc > LAT + 8) begin
                n_chk++; n_fail++;
                $display("FAIL timeout x=%h: got no response expected one after %0d cycles", sb[0].x, LAT);
                void'(sb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [63:0] x, output int waited);
        exp_t e;
        waited      = 0;
        req_val     = 1'b1;
        req_operand = x;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                e.x   = x;
                model(x, e.root, e.rem);
                e.acc = cyc;
                sb.push_back(e);
                @(posedge clk); #1;
                req_val = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rand_bp) resp_rdy = ($urandom_range(0, 2) != 0);
            waited++;
        end
        req_val = 1'b0;
        n_chk++; n_fail++;
        $display("FAIL accept_timeout x=%h: got req_rdy=0 expected 1", x);
    endtask

    task automatic wait_resp(input bit chk_busy);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_val) return;
            if (chk_busy) chk("busy_calc", 64'(busy), 64'd1);
        end
        n_chk++; n_fail++;
        $display("FAIL wait_resp: got resp_val=0 expected 1");
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        n_chk++; n_fail++;
        $display("FAIL drain: got %0d pending expected 0", sb.size());
    endtask

    initial begin
        int          w;
        logic [63:0] x, r64;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_root", 64'(resp_root), 64'd0);
        chk("rst_rem", 64'(resp_rem), 64'd0);

        @(posedge clk); #1;
        issue(64'd144, w);
        @(negedge clk);
        chk("calc_req_rdy", 64'(req_rdy), 64'd0);
        wait_resp(1'b1);
        @(negedge clk);
        chk("busy_after_hs", 64'(busy), 64'd0);
        chk("resp_val_after_hs", 64'(resp_val), 64'd0);

        @(posedge clk); #1;
        issue(64'd0, w);
        drain();
        @(posedge clk); #1;
        issue(64'd10, w);
        drain();
        @(posedge clk); #1;
        issue(64'hFFFF_FFFF_FFFF_FFFF, w);
        drain();

        // Back-pressure, then a same-edge handover to the next operand.
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        issue(64'd1000, w);
        wait_resp(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_req_rdy", 64'(req_rdy), 64'd0);
            chk("bp_resp_val", 64'(resp_val), 64'd1);
        end
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        issue(64'd4, w);
        chk("b2b_wait", 64'(w), 64'd0);
        drain();

        // Flush mid-calculation with a competing request.
        @(posedge clk); #1;
        issue(64'd99, w);
        repeat (4) @(posedge clk);
        #1;
        flush       = 1'b1;
        req_val     = 1'b1;
        req_operand = 64'd7;
        @(negedge clk);
        chk("flush_req_rdy", 64'(req_rdy), 64'd0);
        @(posedge clk); #1;
        flush   = 1'b0;
        req_val = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_resp_val", 64'(resp_val), 64'd0);
        repeat (45) @(posedge clk);
        #1;
        issue(64'd81, w);
        drain();

        // Reset while a result waits in DONE.
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        issue(64'd50, w);
        wait_resp(1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstdone_resp_val", 64'(resp_val), 64'd0);
        chk("rstdone_root", 64'(resp_root), 64'd0);
        chk("rstdone_rem", 64'(resp_rem), 64'd0);
        chk("rstdone_req_rdy", 64'(req_rdy), 64'd1);
        chk("rstdone_busy", 64'(busy), 64'd0);

        // Randomized operands with random consumer back-pressure.
        @(posedge clk); #1;
        rand_bp = 1'b1;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: x = 64'($urandom_range(0, 1000));
                1: x = {$urandom, $urandom};
                2: begin r64 = {32'd0, $urandom}; x = r64 * r64; end
                default: begin r64 = {32'd0, $urandom}; x = r64 * r64 - 64'd1; end
            endcase
            resp_rdy = ($urandom_range(0, 2) != 0);
            issue(x, w);
        end
        rand_bp  = 1'b0;
        resp_rdy = 1'b1;
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
